// File: rtl/linelength_feature.sv
// linelength_feature
// Line-length feature extractor for the EEG detection front end. Each window
// of WIN_LEN first differences |x[n]-x[n-1]| is summed and emitted as one
// signed FEAT_WIDTH-bit word over a valid/ready output handshake. The input
// side stalls only when a finished window cannot be handed off.
//
// Build option: define LL_DIFF_CLIP_EN to clip every difference to CLIP_MAX
// before it is accumulated, which suppresses electrode-pop artifacts. Without
// the macro the raw differences are accumulated and CLIP_MAX is unused.
//
// Control inputs: rst is an asynchronous active-low reset, en is an active-low
// run enable (1 freezes the block while still letting dout be consumed).
module linelength_feature #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FEAT_WIDTH   = 25,
    parameter int WIN_LEN      = 250,
    parameter int CNT_WIDTH    = 8,
    parameter int CLIP_MAX     = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic signed [SAMPLE_WIDTH-1:0] din,
    input  logic                           din_valid,
    output logic                           din_ready,
    output logic signed [FEAT_WIDTH-1:0]   dout,
    output logic                           dout_valid,
    input  logic                           dout_ready
);

    // Difference width: one extra bit so the full-scale swing fits unsigned.
    localparam int                   DIFF_W   = SAMPLE_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WIN_LEN - 1);

    // PRIME: waiting for the first sample after reset (no predecessor yet).
    // ACCUM: summing differences into the current window.
    // STALL: window is full but the previous feature has not been taken.
    typedef enum logic [1:0] {
        PRIME = 2'd0,
        ACCUM = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic                           run_q;
    logic [FEAT_WIDTH-1:0]          acc_q, acc_d;
    logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
    logic signed [SAMPLE_WIDTH-1:0] prev_q, prev_d;
    logic signed [FEAT_WIDTH-1:0]   dout_q, dout_d;
    logic                           dout_valid_q, dout_valid_d;

    logic                           active;
    logic                           at_last;
    logic                           out_blocked;
    logic                           out_fire;
    logic                           accept;
    logic [DIFF_W-1:0]              diff_raw;
    logic [DIFF_W-1:0]              diff_acc;
    logic [FEAT_WIDTH-1:0]          acc_sum;

    // Magnitude of a - b. The subtraction is done one bit wider than the
    // samples so that full-scale opposite-sign inputs cannot overflow; the
    // magnitude is at most 2^SAMPLE_WIDTH - 1 and is returned unsigned.
    function automatic logic [DIFF_W-1:0] abs_diff(
        input logic signed [SAMPLE_WIDTH-1:0] a,
        input logic signed [SAMPLE_WIDTH-1:0] b
    );
        logic signed [DIFF_W-1:0] delta;
        delta = DIFF_W'(a) - DIFF_W'(b);
        return delta[DIFF_W-1] ? $unsigned(-delta) : $unsigned(delta);
    endfunction

`ifdef LL_DIFF_CLIP_EN
    // Saturate a difference at CLIP_MAX.
    function automatic logic [DIFF_W-1:0] clip_diff(input logic [DIFF_W-1:0] d);
        return (d > DIFF_W'(CLIP_MAX)) ? DIFF_W'(CLIP_MAX) : d;
    endfunction
`endif

    assign active      = run_q && !en;
    assign at_last     = (cnt_q == CNT_LAST);
    assign out_blocked = dout_valid_q && !dout_ready;
    assign out_fire    = dout_valid_q && dout_ready;
    assign accept      = din_valid && din_ready;

    assign diff_raw = abs_diff(din, prev_q);
`ifdef LL_DIFF_CLIP_EN
    assign diff_acc = clip_diff(diff_raw);
`else
    assign diff_acc = diff_raw;
`endif
    // Zero-extension: the difference is a non-negative magnitude.
    assign acc_sum = acc_q + FEAT_WIDTH'(diff_acc);

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

    // FSM state register; run_q holds din_ready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PRIME;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // FSM next state; a freeze holds the state wherever it is.
    always_comb begin
        state_d = state_q;
        if (active) begin
            case (state_q)
                PRIME:   if (accept) state_d = ACCUM;
                ACCUM:   if (at_last && out_blocked) state_d = STALL;
                // Leave once nothing is pending downstream; this also covers a
                // feature that was consumed while the block was frozen.
                STALL:   if (!out_blocked) state_d = ACCUM;
                default: state_d = PRIME;
            endcase
        end
    end

    // FSM output: input readiness, with the same-cycle reload path in ACCUM.
    always_comb begin
        din_ready = 1'b0;
        if (active) begin
            case (state_q)
                PRIME:   din_ready = 1'b1;
                ACCUM:   din_ready = !(at_last && out_blocked);
                default: din_ready = 1'b0;
            endcase
        end
    end

    // Datapath next values: accumulate, close the window, manage the output word.
    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;

        if (out_fire) begin
            dout_valid_d = 1'b0;
        end

        if (accept) begin
            // prev always tracks the last accepted sample, so the diff across
            // a window boundary lands in the next window.
            prev_d = din;
            if (state_q == ACCUM) begin
                if (at_last) begin
                    dout_d       = $signed(acc_sum);
                    dout_valid_d = 1'b1;
                    acc_d        = '0;
                    cnt_d        = '0;
                end else begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Datapath registers; reset discards any partial window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

`ifndef SYNTHESIS
    // Parameter sanity: the feature word and window counter must not wrap.
    always @(posedge clk) begin
        assert (FEAT_WIDTH >= SAMPLE_WIDTH + 1 + $clog2(WIN_LEN))
            else $error("linelength_feature: FEAT_WIDTH too narrow for WIN_LEN");
        assert (CNT_WIDTH >= $clog2(WIN_LEN))
            else $error("linelength_feature: CNT_WIDTH too narrow for WIN_LEN");
        assert (CLIP_MAX >= 0)
            else $error("linelength_feature: CLIP_MAX must be non-negative");
    end
`endif

endmodule

// File: tb/tb_linelength_feature.sv
// Bench for linelength_feature: directed scenarios with randomized sample
// values and input gaps, checked against a sample-history reference model.
module tb_linelength_feature;

    localparam int SW = 16;
    localparam int FW = 25;
    localparam int WL = 250;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic signed [SW-1:0] din;
    logic                 din_valid;
    logic                 din_ready;
    logic signed [FW-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready;

    int checks   = 0;
    int failures = 0;
    int hist[$];
    int gap_max  = 0;
    int last_waits;
    int total_waits;
    int rnd[251];
    longint clip_expect;

    always #5 clk = ~clk;

    linelength_feature dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: sum of |difference| over the 250 diffs ending at sample index hi.
    function automatic longint window_sum(input int hi);
        longint s;
        int d;
        s = 0;
        for (int i = hi - WL + 1; i <= hi; i++) begin
            d = hist[i] - hist[i-1];
            if (d < 0) d = -d;
`ifdef LL_DIFF_CLIP_EN
            if (d > 4096) d = 4096;
`endif
            s += d;
        end
        return s;
    endfunction

    // Offer one sample (after an optional random idle gap) until accepted.
    task automatic push(input int x);
        int  gap;
        int  waits;
        bit  ok;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        din_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        din       = SW'(x);
        din_valid = 1'b1;
        ok        = 1'b0;
        waits     = 0;
        while (!ok && waits < 200) begin
            @(negedge clk);
            if (din_ready === 1'b1) ok = 1'b1;
            else waits++;
            @(posedge clk); #1;
        end
        din_valid  = 1'b0;
        last_waits = waits;
        check("accept", ok, 1);
        if (ok) begin
            hist.push_back(x);
            if (hist.size() > WL && (hist.size() - 1) % WL == 0) begin
                check("win_valid", dout_valid, 1);
                check("win_dout", dout, window_sum(hist.size() - 1));
            end
        end
    endtask

    task automatic do_reset();
        din_valid  = 1'b0;
        en         = 1'b0;
        dout_ready = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("rst_dout_valid", dout_valid, 0);
        check("rst_din_ready", din_ready, 0);
        check("rst_dout", dout, 0);
        @(negedge clk);
        rst = 1'b1;
        hist.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        rst        = 1'b0;
        en         = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;

        do_reset();
        @(posedge clk); #1;
        check("ready_after_release", din_ready, 1);

        // Constant input: one pulse with zero sum, never stalls.
        gap_max = 0;
        total_waits = 0;
        for (int i = 0; i < 251; i++) begin
            push(100);
            total_waits += last_waits;
        end
        check("const_dout", dout, 0);
        check("const_valid", dout_valid, 1);
        check("const_stalls", total_waits, 0);
        @(posedge clk); #1;
        check("const_pulse_clears", dout_valid, 0);

        // Alternating 0/1000: two contiguous windows including the boundary diff.
        do_reset();
        for (int i = 0; i < 251; i++) push((i % 2) ? 1000 : 0);
        check("alt_win1", dout, 250000);
        for (int i = 251; i < 501; i++) push((i % 2) ? 1000 : 0);
        check("alt_win2", dout, 250000);

        // Full-scale swings: largest possible sum, sign bit stays clear.
        do_reset();
        for (int i = 0; i < 251; i++) push((i % 2) ? 32767 : -32768);
        check("max_dout", dout, 16383750);
        check("max_msb", dout[FW-1], 0);

        // Backpressure through a second window completion.
        do_reset();
        dout_ready = 1'b0;
        for (int i = 0; i < 251; i++) push((i % 2) ? 10 : 0);
        check("bp_win1", dout, 2500);
        for (int i = 251; i < 500; i++) push((i % 2) ? 10 : 0);
        check("bp_ready_low", din_ready, 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("bp_hold_dout", dout, 2500);
        check("bp_hold_valid", dout_valid, 1);
        check("bp_stall_ready", din_ready, 0);
        // Consume while frozen: the handshake must still complete.
        en         = 1'b1;
        dout_ready = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b0;
        check("bp_consumed", dout_valid, 0);
        en = 1'b0;
        push(0);
        check("bp_win2", dout, 2500);
        check("bp_win2_valid", dout_valid, 1);
        dout_ready = 1'b1;

        // Freeze mid-window with random samples and gaps.
        do_reset();
        gap_max = 2;
        for (int i = 0; i < 251; i++) rnd[i] = int'($urandom_range(65535, 0)) - 32768;
        for (int i = 0; i < 100; i++) push(rnd[i]);
        en        = 1'b1;
        din       = SW'(rnd[100]);
        din_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("freeze_ready", din_ready, 0);
            @(posedge clk); #1;
        end
        en        = 1'b0;
        din_valid = 1'b0;
        for (int i = 100; i < 251; i++) push(rnd[i]);
        gap_max = 0;

        // Asynchronous reset mid-window with a held feature pending.
        do_reset();
        dout_ready = 1'b0;
        for (int i = 0; i < 251; i++) push((i % 2) ? 10 : 0);
        for (int i = 251; i < 371; i++) push((i % 2) ? 10 : 0);
        check("pre_rst_valid", dout_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", dout_valid, 0);
        check("async_rst_ready", din_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        hist.delete();
        dout_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 250; i++) push(int'($urandom_range(2000, 0)) - 1000);
        check("fresh_250_no_valid", dout_valid, 0);
        push(int'($urandom_range(2000, 0)) - 1000);

        // Large alternating steps: clipped or unclipped total.
        do_reset();
        for (int i = 0; i < 251; i++) push((i % 2) ? 10000 : 0);
`ifdef LL_DIFF_CLIP_EN
        clip_expect = 1024000;
`else
        clip_expect = 2500000;
`endif
        check("clip_dout", dout, clip_expect);

        // Random full-range samples over two windows with random gaps.
        do_reset();
        gap_max = 3;
        for (int i = 0; i < 501; i++) push(int'($urandom_range(65535, 0)) - 32768);
        gap_max = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/linelength_feature.md
Name: linelength_feature

Overview:
Front-end feature extractor for the EEG detection path. It consumes raw signed samples at 250 Hz and computes the line-length feature: the sum of |x[n]−x[n−1]| over a window of WIN_LEN samples. It emits one signed 25-bit feature word per window, which is the per-second input stream consumed by the multi-scale baseline averager. A valid/ready handshake on both sides carries backpressure.

Parameters:
SAMPLE_WIDTH, 16, signed raw sample width
FEAT_WIDTH, 25, output feature width; must be ≥ SAMPLE_WIDTH+1+clog2(WIN_LEN)
WIN_LEN, 250, diffs per window (1 s at 250 Hz)
CNT_WIDTH, 8, window counter width; must be ≥ clog2(WIN_LEN)
CLIP_MAX, 4096, per-diff clip ceiling; used only with LL_DIFF_CLIP_EN

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
en  in  1  enable, active-low (0 = run, 1 = freeze)
din  in  SAMPLE_WIDTH  signed raw sample
din_valid  in  1  din carries a sample this cycle
din_ready  out  1  block accepts din this cycle
dout  out  FEAT_WIDTH  signed line-length sum of the completed window
dout_valid  out  1  dout holds an unconsumed feature
dout_ready  in  1  downstream takes dout this cycle

Behaviour:
- Reset (rst=0, async):
  - dout=0, dout_valid=0, din_ready=0.
  - acc=0, cnt=0, prev=0, state=PRIME.
  - A reset mid-window discards the partial sum.
  - Release is synchronous to clk; din_ready may rise one cycle after release.
- Input accept: a sample is accepted when din_valid && din_ready at a clk edge.
- en=1 (freeze):
  - din_ready=0 and all state holds.
  - dout/dout_valid hold, except that a dout_ready handshake still completes and clears dout_valid.
- States:
  - PRIME:
    - din_ready=1 when en=0.
    - Accept stores din into prev; no diff is computed and cnt is not incremented.
    - Next state ACCUM.
  - ACCUM:
    - Per accepted sample: d = |din − prev|, computed in SAMPLE_WIDTH+1 bits as unsigned, max 2^SAMPLE_WIDTH − 1.
    - acc += d, zero-extended to FEAT_WIDTH; prev = din; cnt++.
    - If cnt == WIN_LEN−1 on accept, the window completes:
      - dout ← acc + d, dout_valid ← 1 on the same edge.
      - acc ← 0, cnt ← 0.
      - prev keeps the last sample, so windows are contiguous and a window-boundary diff is never lost.
    - If cnt == WIN_LEN−1 and (dout_valid && !dout_ready), go to STALL.
  - STALL:
    - din_ready=0.
    - On dout_ready while dout_valid, return to ACCUM in the next cycle.
    - In STALL, din_ready is a registered function of state; the fast path in the next item does not apply.
- din_ready in ACCUM is 0 only when cnt == WIN_LEN−1 && dout_valid && !dout_ready. Same-cycle reload is allowed when dout_ready=1.
- Latency: dout_valid rises on the clock edge that accepts the WIN_LEN-th diff sample, which is the (WIN_LEN+1)-th sample after reset.
- Output handshake:
  - dout and dout_valid are stable until consumed.
  - dout_valid clears on dout_valid && dout_ready unless a new window completes on the same edge, in which case it stays 1 with the new dout.
- Width/overflow: with default parameters the maximum sum is 250 × 65535 = 16,383,750 < 2^24, so no wrap is possible. Parameter sets violating the FEAT_WIDTH rule are unsupported; a simulation-only assertion flags them.
- dout is signed by type, but its MSB is always 0 because the sum is non-negative.

Optional Feature:
- LL_DIFF_CLIP_EN defined: each diff is clipped before accumulation, d' = min(d, CLIP_MAX). This rejects electrode-pop artifacts.
- Undefined: d is accumulated unclipped and CLIP_MAX is ignored.

Test Plan:
- Constant din=100, 251 samples, dout_ready=1 → exactly one dout_valid pulse with dout=0; din_ready stays 1 throughout.
- Alternating 0,1000 (first 0 primes), 251 samples → dout=250000; next 250 samples of the same pattern → dout=250000 again, with the boundary diff counted.
- Alternating −32768,32767, 251 samples → dout=16383750; MSB=0, no wrap.
- dout_ready=0 through a second window completion with the pattern 0/10 → first dout=2500 stays held; din_ready=0 at cnt=249; after one dout_ready pulse, second window completes → dout=2500, and no samples are lost.
- en=1 for 20 cycles mid-window, then resume → same dout as the uninterrupted run.
- rst=0 asserted asynchronously mid-cycle at cnt=120 → dout_valid=0 and din_ready=0 immediately; the next window needs 251 fresh samples.
- Alternating 0/10000 (last line used for the optional feature) → 2500000 without LL_DIFF_CLIP_EN; 1024000 with it (CLIP_MAX=4096).
